// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: op codes, register index width, data width.
package alu_pkg;

    localparam int NREG      = 8;
    localparam int REG_IDX_W = 3;
    localparam int XLEN      = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

    // ALU control codes; OP_LI never reaches the ALU's datapath meaningfully
    localparam logic [3:0] OP_LI   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SLT  = 4'h3;
    localparam logic [3:0] OP_SLTU = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SLL  = 4'h9;
    localparam logic [3:0] OP_SRL  = 4'hA;
    localparam logic [3:0] OP_SRA  = 4'hB;
    localparam logic [3:0] OP_LUI  = 4'hC;
    localparam logic [3:0] OP_NOT  = 4'hD;
    localparam logic [3:0] OP_NAND = 4'hE;
    localparam logic [3:0] OP_SGT  = 4'hF;

endpackage

// File: rtl/alu_regfile.sv
// 8x32 register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
module alu_regfile
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    input  reg_idx_t ra_addr,
    output word_t    ra_data,
    input  reg_idx_t rb_addr,
    output word_t    rb_data,
    input  logic     we,
    input  reg_idx_t wa,
    input  word_t    wd
);

    word_t regs_reg [NREG];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            // entry 0 is never written, so it always reads back as zero
            for (int i = 1; i < NREG; i++) begin
                if (we && (wa == REG_IDX_W'(i))) begin
                    regs_reg[i] <= wd;
                end
            end
        end
    end

    assign ra_data = regs_reg[ra_addr];
    assign rb_data = regs_reg[rb_addr];

endmodule

// File: rtl/alu_issue.sv
// Two-stage issuer: EX stage presents registered operands to an external ALU, result stage
// writes back and returns each result over a valid/ready port.
module alu_issue
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_op,
    input  logic [2:0]     cmd_rd,
    input  logic [2:0]     cmd_rs,
    input  logic [2:0]     cmd_rt,
    input  logic [31:0]    cmd_imm,
    output logic [3:0]     alu_control,
    output logic [31:0]    alu_src1,
    output logic [31:0]    alu_src2,
    input  logic [31:0]    alu_result,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2:0]     res_rd,
    output logic [31:0]    res_data
);

    logic     ex_valid_reg;
    reg_idx_t ex_rd_reg;
    word_t    ex_imm_reg;
    logic     ex_li_reg;

    logic     ex_adv;
    logic     accept;
    word_t    ex_result;
    word_t    rf_rs_data;
    word_t    rf_rt_data;
    word_t    src1_next;
    word_t    src2_next;

    alu_regfile u_regfile (
        .clk     (clk),
        .resetn  (resetn),
        .ra_addr (cmd_rs),
        .ra_data (rf_rs_data),
        .rb_addr (cmd_rt),
        .rb_data (rf_rt_data),
        .we      (ex_adv),
        .wa      (ex_rd_reg),
        .wd      (ex_result)
    );

    assign ex_adv    = ex_valid_reg & (~res_valid | res_ready);
    assign cmd_ready = ~ex_valid_reg | ex_adv;
    assign accept    = cmd_valid & cmd_ready;
    assign ex_result = ex_li_reg ? ex_imm_reg : alu_result;

    // The retiring EX result is not yet in the regfile on the accept edge, so bypass it
    always_comb begin
        src1_next = rf_rs_data;
        src2_next = rf_rt_data;
        if (ex_adv && (ex_rd_reg != '0) && (ex_rd_reg == cmd_rs)) begin
            src1_next = ex_result;
        end
        if (ex_adv && (ex_rd_reg != '0) && (ex_rd_reg == cmd_rt)) begin
            src2_next = ex_result;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid_reg <= 1'b0;
            alu_control  <= OP_LI;
            alu_src1     <= '0;
            alu_src2     <= '0;
            ex_rd_reg    <= '0;
            ex_imm_reg   <= '0;
            ex_li_reg    <= 1'b0;
        end else if (accept) begin
            ex_valid_reg <= 1'b1;
            alu_control  <= cmd_op;
            alu_src1     <= src1_next;
            alu_src2     <= src2_next;
            ex_rd_reg    <= cmd_rd;
            ex_imm_reg   <= cmd_imm;
            ex_li_reg    <= (cmd_op == OP_LI);
        end else if (ex_adv) begin
            ex_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_data  <= '0;
        end else if (ex_adv) begin
            res_valid <= 1'b1;
            res_rd    <= ex_rd_reg;
            res_data  <= ex_result;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a behavioural ALU closes the loop, an in-order register model predicts responses.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rs, cmd_rt;
    logic [31:0] cmd_imm;
    logic [3:0]  alu_control;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_rd;
    logic [31:0] res_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mreg [8];
    logic [34:0] exp_q [$];

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs      (cmd_rs),
        .cmd_rt      (cmd_rt),
        .cmd_imm     (cmd_imm),
        .alu_control (alu_control),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_result  (alu_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_rd      (res_rd),
        .res_data    (res_data)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h1: return a + b;
            4'h2: return a - b;
            4'h3: return {31'b0, $signed(a) < $signed(b)};
            4'h4: return {31'b0, a < b};
            4'h5: return a & b;
            4'h6: return ~(a | b);
            4'h7: return a | b;
            4'h8: return a ^ b;
            4'h9: return b << a[4:0];
            4'hA: return b >> a[4:0];
            4'hB: return $unsigned($signed(b) >>> a[4:0]);
            4'hC: return {b[15:0], 16'h0};
            4'hD: return ~b;
            4'hE: return ~(a & b);
            4'hF: return {31'b0, $signed(a) > $signed(b)};
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_control, alu_src1, alu_src2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge; monitor samples on negedge
    always @(negedge clk) begin
        if (resetn && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_res", {29'b0, res_rd}, 32'hFFFF_FFFF);
            end else begin
                logic [34:0] e;
                e = exp_q.pop_front();
                $display("res  rd=%0d data=0x%08h (exp rd=%0d data=0x%08h)", res_rd, res_data, e[34:32], e[31:0]);
                chk("res_rd", {29'b0, res_rd}, {29'b0, e[34:32]});
                chk("res_data", res_data, e[31:0]);
            end
        end
    end

    // Drives one command, waits for acceptance (bounded), updates the model and the scoreboard
    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [31:0] imm, output int waits);
        logic [31:0] r;
        waits = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
        @(negedge clk);
        while (!cmd_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
        end else begin
            r = (op == 4'h0) ? imm : alu_f(op, mreg[rs], mreg[rt]);
            if (rd != 3'd0) mreg[rd] = r;
            exp_q.push_back({rd, r});
            $display("cmd  op=%h rd=%0d rs=%0d rt=%0d imm=0x%08h -> exp 0x%08h", op, rd, rs, rt, imm, r);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int w;
        logic [31:0] s1, s2;
        logic [3:0]  c;
        for (int i = 0; i < 8; i++) mreg[i] = 32'h0;
        resetn = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
        cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0; cmd_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("rst_alu_ctrl", {28'b0, alu_control}, 32'h0);
        chk("rst_src1", alu_src1, 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'b0, cmd_ready}, 32'h1);

        // Basic LI/add
        send(4'h0, 3'd1, 3'd0, 3'd0, 32'h0000_0005, w);
        send(4'h0, 3'd2, 3'd0, 3'd0, 32'hFFFF_FFFD, w);
        send(4'h1, 3'd3, 3'd1, 3'd2, 32'h0, w);
        chk("add_nostall", w, 0);
        drain();

        // Forward chain, no bubbles
        send(4'h0, 3'd1, 3'd0, 3'd0, 32'h7, w);
        send(4'h2, 3'd1, 3'd1, 3'd1, 32'h0, w);
        chk("fwd1_nostall", w, 0);
        send(4'h7, 3'd2, 3'd1, 3'd1, 32'h0, w);
        chk("fwd2_nostall", w, 0);
        drain();

        // Compares and shifts
        send(4'h0, 3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF, w);
        send(4'h0, 3'd2, 3'd0, 3'd0, 32'h1, w);
        send(4'h3, 3'd3, 3'd1, 3'd2, 32'h0, w);
        send(4'h4, 3'd4, 3'd1, 3'd2, 32'h0, w);
        send(4'hF, 3'd5, 3'd1, 3'd2, 32'h0, w);
        send(4'h0, 3'd1, 3'd0, 3'd0, 32'h4, w);
        send(4'h0, 3'd2, 3'd0, 3'd0, 32'h8000_0000, w);
        send(4'hB, 3'd6, 3'd1, 3'd2, 32'h0, w);
        send(4'hC, 3'd7, 3'd0, 3'd1, 32'h0, w);
        send(4'hE, 3'd7, 3'd7, 3'd6, 32'h0, w);
        drain();

        // Backpressure with two commands pending
        res_ready = 1'b0;
        send(4'h1, 3'd5, 3'd1, 3'd1, 32'h0, w);
        send(4'h8, 3'd6, 3'd2, 3'd1, 32'h0, w);
        s1 = alu_src1; s2 = alu_src2; c = alu_control;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
            chk("bp_src1", alu_src1, s1);
            chk("bp_src2", alu_src2, s2);
            chk("bp_ctrl", {28'b0, alu_control}, {28'b0, c});
            chk("bp_res_valid", {31'b0, res_valid}, 32'h1);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        drain();

        // r0 writes dropped but reported
        send(4'h0, 3'd0, 3'd0, 3'd0, 32'h1234, w);
        send(4'h1, 3'd4, 3'd0, 3'd0, 32'h0, w);
        drain();

        // Reset mid-operation
        res_ready = 1'b0;
        send(4'h0, 3'd3, 3'd0, 3'd0, 32'hDEAD_BEEF, w);
        send(4'h0, 3'd4, 3'd0, 3'd0, 32'hCAFE_F00D, w);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("mid_rst_res_data", res_data, 32'h0);
        chk("mid_rst_src1", alu_src1, 32'h0);
        chk("mid_rst_ready", {31'b0, cmd_ready}, 32'h1);
        exp_q.delete();
        for (int i = 0; i < 8; i++) mreg[i] = 32'h0;
        @(posedge clk); #1;
        resetn = 1'b1;
        res_ready = 1'b1;
        send(4'h7, 3'd5, 3'd3, 3'd4, 32'h0, w);
        send(4'h1, 3'd6, 3'd1, 3'd2, 32'h0, w);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
